uart_tx_engine: RTL and testbench
=================================

// Module: uart_tx_engine
// PURPOSE
//  Serialises one byte per handshake into an asynchronous UART frame:
//  start bit, 5..8 data bits LSB-first, optional parity, 1/1.5/2 stop bits.
//  Sits in the UART driver, directly downstream of the AXI-Lite TX FIFO logic.
//  Consumes i_user_tx_data/valid and reports completion on o_user_tx_ready.
// PARAMETERS
//  P_DIV_WIDTH   24  width of the baud divisor (clocks per bit)
//  P_DATA_WIDTH  8   width of the user data word
// PORTS
//  clock            in   1   single clock, all logic on rising edge
//  reset            in   1   synchronous, active-high reset
//  i_user_tx_data   in   8   byte to transmit
//  i_user_tx_valid  in   1   byte available
//  o_user_tx_ready  out  1   engine idle and able to accept
//  i_div_num        in   24  clocks per bit; values <2 are treated as 2
//  i_data_bit       in   4   data bits 5..8; any other value means 8
//  i_stop_bit       in   2   00=1, 01=1.5, 10=2, 11=2 stop bits
//  i_check_bit      in   2   00=none, 01=odd, 10=even, 11=mark (parity bit 1)
//  i_uart_cts       in   1   clear-to-send, active-low (used only with UART_TX_CTS_EN)
//  o_uart_tx        out  1   serial line, idle high
// BEHAVIOUR
//  - Reset: state IDLE, o_uart_tx=1, o_user_tx_ready=1 (CTS permitting), counters 0.
//  - Reset mid-frame aborts the frame; o_uart_tx=1 on the cycle after reset is sampled.
//  - o_user_tx_ready = (state==IDLE) & cts_ok. It is combinational from registered state.
//  - Accept: valid&ready on edge N. Data, div, data_bit, stop_bit and check_bit are latched.
//    The start bit (o_uart_tx=0) is driven from cycle N+1. Ready is low from N+1.
//  - Config inputs changing mid-frame have no effect until the next accept.
//  - FSM: IDLE->START->DATA->(PARITY if check!=0)->STOP->IDLE.
//    Each bit lasts D=max(div,2) cycles, counted by the bit-timer down-counter.
//  - DATA shifts the latched byte right and sends bit[0] for N data bits.
//  - Parity is computed over the low N bits only. odd = ~^d, even = ^d, mark = 1.
//  - STOP is high for 1 bit (D), 1.5 bits (D + D>>1) or 2 bits (2D).
//  - Frame length = (1+N+P)*D + stop cycles. Ready returns high on the first cycle
//    after the last stop cycle, a clean rising edge for upstream edge detection.
//  - A valid already high in IDLE is accepted immediately; there is no back-to-back
//    gap beyond the IDLE cycle.
//  - valid while not ready is ignored; data is not held on the engine's behalf.
// CONFIGURATION
//  UART_TX_CTS_EN defined: cts_ok = ~i_uart_cts. With CTS high, IDLE holds ready=0
//    and no new frame starts. A frame in progress always completes.
//  UART_TX_CTS_EN undefined: cts_ok = 1 and i_uart_cts is ignored.
// STRUCTURE
//  - uart_pkg holds the state encoding (IDLE/START/DATA/PARITY/STOP),
//    CHECK_NONE/ODD/EVEN/MARK, STOP_1/STOP_1P5/STOP_2, and DIV_MIN=2.
//  - Sub-module uart_bit_timer: loadable P_DIV_WIDTH+1 down-counter that produces
//    a 1-cycle bit_done pulse. It is shared by the RX engine.
// TESTING
//  1. div=16, 8N1, data=0x55 accepted at N: tx=0 over N+1..N+16, then 1,0,1,0,1,0,1,0
//     (16 cycles each), stop high 16 cycles; ready high at N+161.
//  2. div=10, 7 bits, even parity, data=0x13: parity bit=1, frame 100 cycles incl. 1 stop.
//     The same with odd parity gives parity bit=0.
//  3. div=16, 8N, stop=01: stop high for exactly 24 cycles; ready high at N+169.
//  4. div=0 and div=1: bit time is 2 cycles; 8N1 frame of 0xFF is 20 cycles.
//  5. UART_TX_CTS_EN with cts=1 and valid=1: ready=0 and tx=1 for 50 cycles.
//     Drop cts: accept the next cycle. Raise cts mid-frame: the frame completes.
//  6. Reset asserted at the 3rd data bit: next cycle tx=1 and ready=1.
//     A new 0xA5 frame is then transmitted correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART encodings: FSM states, parity modes, stop-bit modes, and the
// minimum bit time. Used by the TX engine and the bit timer's users.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  typedef enum logic [1:0] {
    CHECK_NONE = 2'b00,
    CHECK_ODD  = 2'b01,
    CHECK_EVEN = 2'b10,
    CHECK_MARK = 2'b11
  } check_e;

  typedef enum logic [1:0] {
    STOP_1   = 2'b00,
    STOP_1P5 = 2'b01,
    STOP_2   = 2'b10
  } stop_e;

  localparam int unsigned DIV_MIN = 2;

  // Data-bit setting outside 5..8 falls back to 8 bits.
  function automatic logic [3:0] eff_data_bits(input logic [3:0] b);
    return (b >= 4'd5 && b <= 4'd8) ? b : 4'd8;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter producing a single-cycle bit_done pulse on the last
// cycle of a loaded period. Shared by the UART TX and RX engines.
module uart_bit_timer #(
  parameter int unsigned P_WIDTH = 25
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [P_WIDTH-1:0] load_val,
  output logic               bit_done
);

  logic [P_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A load of D gives D cycles, the last of which asserts bit_done.
  assign bit_done = (cnt_q == P_WIDTH'(1));

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: start, 5..8 data bits LSB-first, optional parity,
// 1/1.5/2 stop bits. Define UART_TX_CTS_EN to gate frame starts on CTS.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int unsigned P_DIV_WIDTH  = 24,
  parameter int unsigned P_DATA_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [P_DATA_WIDTH-1:0] i_user_tx_data,
  input  logic                    i_user_tx_valid,
  output logic                    o_user_tx_ready,
  input  logic [P_DIV_WIDTH-1:0]  i_div_num,
  input  logic [3:0]              i_data_bit,
  input  logic [1:0]              i_stop_bit,
  input  logic [1:0]              i_check_bit,
  input  logic                    i_uart_cts,
  output logic                    o_uart_tx
);

  state_e                  state_q, state_d;
  logic [P_DATA_WIDTH-1:0] shift_q, shift_d;
  logic [3:0]              bits_q, bits_d;
  logic [P_DIV_WIDTH-1:0]  div_q, div_d;
  logic [1:0]              stop_q, stop_d;
  check_e                  check_q, check_d;
  logic                    parity_q, parity_d;

  logic                    cts_ok;
  logic                    timer_load;
  logic [P_DIV_WIDTH:0]    timer_val;
  logic                    bit_done;
  logic [P_DIV_WIDTH-1:0]  div_in;
  logic [3:0]              nbits_in;
  logic                    par_x, par_in;
  logic [P_DIV_WIDTH:0]    bit_len, stop_len;

`ifdef UART_TX_CTS_EN
  assign cts_ok = ~i_uart_cts;
`else
  logic unused_cts;
  assign unused_cts = i_uart_cts;
  assign cts_ok     = 1'b1;
`endif

  assign div_in   = (i_div_num < P_DIV_WIDTH'(DIV_MIN)) ? P_DIV_WIDTH'(DIV_MIN) : i_div_num;
  assign nbits_in = eff_data_bits(i_data_bit);
  assign bit_len  = {1'b0, div_q};

  // Parity is resolved at accept time over only the bits that will be sent.
  always_comb begin
    par_x = 1'b0;
    for (int unsigned i = 0; i < P_DATA_WIDTH; i++) begin
      if (i < 32'(nbits_in)) par_x = par_x ^ i_user_tx_data[i];
    end
    case (check_e'(i_check_bit))
      CHECK_ODD:  par_in = ~par_x;
      CHECK_EVEN: par_in = par_x;
      CHECK_MARK: par_in = 1'b1;
      default:    par_in = 1'b0;
    endcase
  end

  always_comb begin
    case (stop_q)
      STOP_1:   stop_len = bit_len;
      STOP_1P5: stop_len = bit_len + (bit_len >> 1);
      default:  stop_len = bit_len << 1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bits_d     = bits_q;
    div_d      = div_q;
    stop_d     = stop_q;
    check_d    = check_q;
    parity_d   = parity_q;
    timer_load = 1'b0;
    timer_val  = bit_len;
    case (state_q)
      IDLE: begin
        if (i_user_tx_valid && cts_ok) begin
          shift_d    = i_user_tx_data;
          bits_d     = nbits_in;
          div_d      = div_in;
          stop_d     = i_stop_bit;
          check_d    = check_e'(i_check_bit);
          parity_d   = par_in;
          timer_load = 1'b1;
          timer_val  = {1'b0, div_in};
          state_d    = START;
        end
      end
      START: begin
        if (bit_done) begin
          timer_load = 1'b1;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d    = shift_q >> 1;
          bits_d     = bits_q - 4'd1;
          timer_load = 1'b1;
          if (bits_q == 4'd1) begin
            if (check_q != CHECK_NONE) begin
              state_d = PARITY;
            end else begin
              timer_val = stop_len;
              state_d   = STOP;
            end
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          timer_load = 1'b1;
          timer_val  = stop_len;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (bit_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bits_q   <= '0;
      div_q    <= '0;
      stop_q   <= '0;
      check_q  <= CHECK_NONE;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bits_q   <= bits_d;
      div_q    <= div_d;
      stop_q   <= stop_d;
      check_q  <= check_d;
      parity_q <= parity_d;
    end
  end

  uart_bit_timer #(
    .P_WIDTH (P_DIV_WIDTH + 1)
  ) u_bit_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .bit_done (bit_done)
  );

  assign o_user_tx_ready = (state_q == IDLE) && cts_ok;

  always_comb begin
    case (state_q)
      START:   o_uart_tx = 1'b0;
      DATA:    o_uart_tx = shift_q[0];
      PARITY:  o_uart_tx = parity_q;
      default: o_uart_tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed self-checking bench for uart_tx_engine; the CTS scenario follows
// whether UART_TX_CTS_EN is defined for the build.
module tb_uart_tx_engine;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  i_user_tx_data = '0;
  logic        i_user_tx_valid = 1'b0;
  logic        o_user_tx_ready;
  logic [23:0] i_div_num = 24'd16;
  logic [3:0]  i_data_bit = 4'd8;
  logic [1:0]  i_stop_bit = 2'b00;
  logic [1:0]  i_check_bit = 2'b00;
  logic        i_uart_cts = 1'b0;
  logic        o_uart_tx;

  int tests_run = 0;
  int tests_failed = 0;
  logic cap [0:1023];
  int cap_len = 0;
  int bad;

  always #5 clock = ~clock;

  uart_tx_engine #(
    .P_DIV_WIDTH  (24),
    .P_DATA_WIDTH (8)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .i_user_tx_data  (i_user_tx_data),
    .i_user_tx_valid (i_user_tx_valid),
    .o_user_tx_ready (o_user_tx_ready),
    .i_div_num       (i_div_num),
    .i_data_bit      (i_data_bit),
    .i_stop_bit      (i_stop_bit),
    .i_check_bit     (i_check_bit),
    .i_uart_cts      (i_uart_cts),
    .o_uart_tx       (o_uart_tx)
  );

  // fv[k] is the level of bit period k (start first); past nfb periods the line is high.
  function automatic logic exp_tx(input logic [15:0] fv, input int nfb, input int d, input int i);
    if (i / d < nfb) return fv[i / d];
    return 1'b1;
  endfunction

  function automatic int first_bad(input logic [15:0] fv, input int nfb, input int d);
    for (int i = 0; i < cap_len; i++) begin
      if (cap[i] !== exp_tx(fv, nfb, d, i)) return i;
    end
    return -1;
  endfunction

  // Records tx from the current negedge until ready is seen high (bounded).
  task automatic capture();
    cap_len = 0;
    while (o_user_tx_ready !== 1'b1 && cap_len < 1000) begin
      cap[cap_len] = o_uart_tx;
      cap_len++;
      @(negedge clock);
    end
  endtask

  // Accepts one byte, then scrambles every input so mid-frame changes are exercised.
  task automatic run_frame(input logic [7:0] data, input logic [23:0] div,
                           input logic [3:0] dbits, input logic [1:0] stop,
                           input logic [1:0] chk);
    @(negedge clock);
    i_user_tx_data  = data;
    i_div_num       = div;
    i_data_bit      = dbits;
    i_stop_bit      = stop;
    i_check_bit     = chk;
    i_user_tx_valid = 1'b1;
    @(negedge clock);
    i_user_tx_valid = 1'b0;
    i_user_tx_data  = ~data;
    i_div_num       = 24'd7;
    i_data_bit      = 4'd5;
    i_stop_bit      = 2'b10;
    i_check_bit     = 2'b11;
    capture();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    tests_run++;
    if (o_uart_tx !== 1'b1 || o_user_tx_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_hold: tx=%b ready=%b expected tx=1 ready=1", o_uart_tx, o_user_tx_ready);
    end
    reset = 1'b0;
    @(negedge clock);
    tests_run++;
    if (o_uart_tx !== 1'b1 || o_user_tx_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release: tx=%b ready=%b expected tx=1 ready=1", o_uart_tx, o_user_tx_ready);
    end
  endtask

  task automatic test_8n1();
    run_frame(8'h55, 24'd16, 4'd8, 2'b00, 2'b00);
    tests_run++;
    if (cap_len !== 160) begin
      tests_failed++;
      $display("FAIL 8n1_len: got %0d cycles expected 160", cap_len);
    end
    bad = first_bad(16'(10'b1010101010), 10, 16);
    tests_run++;
    if (bad !== -1) begin
      tests_failed++;
      $display("FAIL 8n1_wave: cycle %0d tx=%b expected %b", bad, cap[bad], exp_tx(16'(10'b1010101010), 10, 16, bad));
    end
  endtask

  task automatic test_parity();
    logic [7:0]  data [0:3] = '{8'h13, 8'h13, 8'h93, 8'hEA};
    logic [23:0] div  [0:3] = '{24'd10, 24'd10, 24'd10, 24'd2};
    logic [3:0]  nb   [0:3] = '{4'd7, 4'd7, 4'd7, 4'd5};
    logic [1:0]  chk  [0:3] = '{2'b10, 2'b01, 2'b10, 2'b11};
    logic [15:0] fv   [0:3] = '{16'(10'b1100100110), 16'(10'b1000100110),
                                16'(10'b1100100110), 16'(8'b11010100)};
    int          nfb  [0:3] = '{10, 10, 10, 8};
    int          len  [0:3] = '{100, 100, 100, 16};
    for (int v = 0; v < 4; v++) begin
      run_frame(data[v], div[v], nb[v], 2'b00, chk[v]);
      tests_run++;
      if (cap_len !== len[v]) begin
        tests_failed++;
        $display("FAIL parity_len[%0d]: got %0d cycles expected %0d", v, cap_len, len[v]);
      end
      bad = first_bad(fv[v], nfb[v], int'(div[v]));
      tests_run++;
      if (bad !== -1) begin
        tests_failed++;
        $display("FAIL parity_wave[%0d]: cycle %0d tx=%b expected %b", v, bad, cap[bad],
                 exp_tx(fv[v], nfb[v], int'(div[v]), bad));
      end
    end
  endtask

  task automatic test_stop();
    logic [23:0] div  [0:3] = '{24'd16, 24'd4, 24'd4, 24'd5};
    logic [1:0]  stop [0:3] = '{2'b01, 2'b10, 2'b11, 2'b01};
    int          len  [0:3] = '{168, 44, 44, 52};
    for (int v = 0; v < 4; v++) begin
      run_frame(8'hF0, div[v], 4'd8, stop[v], 2'b00);
      tests_run++;
      if (cap_len !== len[v]) begin
        tests_failed++;
        $display("FAIL stop_len[%0d]: got %0d cycles expected %0d", v, cap_len, len[v]);
      end
      bad = first_bad(16'(9'b111100000), 9, int'(div[v]));
      tests_run++;
      if (bad !== -1) begin
        tests_failed++;
        $display("FAIL stop_wave[%0d]: cycle %0d tx=%b expected %b", v, bad, cap[bad],
                 exp_tx(16'(9'b111100000), 9, int'(div[v]), bad));
      end
    end
  endtask

  task automatic test_min_div();
    logic [7:0]  data [0:3] = '{8'hFF, 8'hFF, 8'h00, 8'h00};
    logic [23:0] div  [0:3] = '{24'd0, 24'd1, 24'd2, 24'd2};
    logic [3:0]  nb   [0:3] = '{4'd8, 4'd8, 4'd9, 4'd0};
    logic [15:0] fv   [0:3] = '{16'(10'b1111111110), 16'(10'b1111111110),
                                16'(10'b1000000000), 16'(10'b1000000000)};
    for (int v = 0; v < 4; v++) begin
      run_frame(data[v], div[v], nb[v], 2'b00, 2'b00);
      tests_run++;
      if (cap_len !== 20) begin
        tests_failed++;
        $display("FAIL min_div_len[%0d]: got %0d cycles expected 20", v, cap_len);
      end
      bad = first_bad(fv[v], 10, 2);
      tests_run++;
      if (bad !== -1) begin
        tests_failed++;
        $display("FAIL min_div_wave[%0d]: cycle %0d tx=%b expected %b", v, bad, cap[bad], exp_tx(fv[v], 10, 2, bad));
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    i_user_tx_data  = 8'h0F;
    i_div_num       = 24'd2;
    i_data_bit      = 4'd8;
    i_stop_bit      = 2'b00;
    i_check_bit     = 2'b00;
    i_user_tx_valid = 1'b1;
    @(negedge clock);
    i_user_tx_data = 8'hF0;
    capture();
    tests_run++;
    if (cap_len !== 20) begin
      tests_failed++;
      $display("FAIL b2b_first_len: got %0d cycles expected 20", cap_len);
    end
    bad = first_bad(16'(10'b1000011110), 10, 2);
    tests_run++;
    if (bad !== -1) begin
      tests_failed++;
      $display("FAIL b2b_first_wave: cycle %0d tx=%b expected %b", bad, cap[bad], exp_tx(16'(10'b1000011110), 10, 2, bad));
    end
    @(negedge clock);
    i_user_tx_valid = 1'b0;
    capture();
    tests_run++;
    if (cap_len !== 20) begin
      tests_failed++;
      $display("FAIL b2b_second_len: got %0d cycles expected 20", cap_len);
    end
    bad = first_bad(16'(10'b1111100000), 10, 2);
    tests_run++;
    if (bad !== -1) begin
      tests_failed++;
      $display("FAIL b2b_second_wave: cycle %0d tx=%b expected %b", bad, cap[bad], exp_tx(16'(10'b1111100000), 10, 2, bad));
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    i_user_tx_data  = 8'h00;
    i_div_num       = 24'd4;
    i_data_bit      = 4'd8;
    i_stop_bit      = 2'b00;
    i_check_bit     = 2'b00;
    i_user_tx_valid = 1'b1;
    @(negedge clock);
    i_user_tx_valid = 1'b0;
    repeat (13) @(negedge clock);
    tests_run++;
    if (o_uart_tx !== 1'b0 || o_user_tx_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_frame_bit2: tx=%b ready=%b expected tx=0 ready=0", o_uart_tx, o_user_tx_ready);
    end
    reset = 1'b1;
    @(negedge clock);
    tests_run++;
    if (o_uart_tx !== 1'b1 || o_user_tx_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_abort: tx=%b ready=%b expected tx=1 ready=1", o_uart_tx, o_user_tx_ready);
    end
    reset = 1'b0;
    run_frame(8'hA5, 24'd4, 4'd8, 2'b00, 2'b00);
    tests_run++;
    if (cap_len !== 40) begin
      tests_failed++;
      $display("FAIL after_reset_len: got %0d cycles expected 40", cap_len);
    end
    bad = first_bad(16'(10'b1101001010), 10, 4);
    tests_run++;
    if (bad !== -1) begin
      tests_failed++;
      $display("FAIL after_reset_wave: cycle %0d tx=%b expected %b", bad, cap[bad], exp_tx(16'(10'b1101001010), 10, 4, bad));
    end
  endtask

`ifdef UART_TX_CTS_EN
  task automatic test_cts();
    @(negedge clock);
    i_uart_cts      = 1'b1;
    i_user_tx_data  = 8'h00;
    i_div_num       = 24'd2;
    i_data_bit      = 4'd8;
    i_stop_bit      = 2'b00;
    i_check_bit     = 2'b00;
    i_user_tx_valid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      tests_run++;
      if (o_user_tx_ready !== 1'b0 || o_uart_tx !== 1'b1) begin
        tests_failed++;
        $display("FAIL cts_hold cycle %0d: ready=%b tx=%b expected ready=0 tx=1", c, o_user_tx_ready, o_uart_tx);
      end
    end
    i_uart_cts = 1'b0;
    #1;
    tests_run++;
    if (o_user_tx_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL cts_drop_ready: ready=%b expected 1", o_user_tx_ready);
    end
    @(negedge clock);
    i_user_tx_valid = 1'b0;
    cap_len = 20;
    for (int i = 0; i < 20; i++) begin
      cap[i] = o_uart_tx;
      if (i == 5) i_uart_cts = 1'b1;
      @(negedge clock);
    end
    bad = first_bad(16'(10'b1000000000), 10, 2);
    tests_run++;
    if (bad !== -1) begin
      tests_failed++;
      $display("FAIL cts_frame_wave: cycle %0d tx=%b expected %b", bad, cap[bad], exp_tx(16'(10'b1000000000), 10, 2, bad));
    end
    tests_run++;
    if (o_user_tx_ready !== 1'b0 || o_uart_tx !== 1'b1) begin
      tests_failed++;
      $display("FAIL cts_after_frame: ready=%b tx=%b expected ready=0 tx=1", o_user_tx_ready, o_uart_tx);
    end
    i_uart_cts = 1'b0;
    #1;
    tests_run++;
    if (o_user_tx_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL cts_release: ready=%b expected 1", o_user_tx_ready);
    end
  endtask
`else
  task automatic test_cts();
    @(negedge clock);
    i_uart_cts = 1'b1;
    #1;
    tests_run++;
    if (o_user_tx_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL cts_ignored_ready: ready=%b expected 1", o_user_tx_ready);
    end
    run_frame(8'h3C, 24'd2, 4'd8, 2'b00, 2'b00);
    tests_run++;
    if (cap_len !== 20) begin
      tests_failed++;
      $display("FAIL cts_ignored_len: got %0d cycles expected 20", cap_len);
    end
    bad = first_bad(16'(10'b1001111000), 10, 2);
    tests_run++;
    if (bad !== -1) begin
      tests_failed++;
      $display("FAIL cts_ignored_wave: cycle %0d tx=%b expected %b", bad, cap[bad], exp_tx(16'(10'b1001111000), 10, 2, bad));
    end
    i_uart_cts = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_stop();
    test_min_div();
    test_back_to_back();
    test_reset_mid();
    test_cts();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
